// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the CPU controller and the multicycle ALU.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [4:0]       AluOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             aludone;

  modport master (
    output start, AluOp, A, B,
    input  result, zero, hi, lo, busy, aludone
  );

  modport slave (
    input  start, AluOp, A, B,
    output result, zero, hi, lo, busy, aludone
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/add/shift ops, iterative 32-step mul/div into HI/LO.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  multicycle_alu_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd16, OP_MFLO = 5'd17;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   single_res;
  logic               is_md;
  logic               sgn_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, rem_sh;
  logic [2*WIDTH-1:0] prod;

  // Result of every op that completes in the request cycle
  always_comb begin
    single_res = '0;
    case (bus.AluOp)
      OP_ADD:  single_res = bus.A + bus.B;
      OP_SUB:  single_res = bus.A - bus.B;
      OP_AND:  single_res = bus.A & bus.B;
      OP_OR:   single_res = bus.A | bus.B;
      OP_XOR:  single_res = bus.A ^ bus.B;
      OP_NOR:  single_res = ~(bus.A | bus.B);
      OP_SLT:  single_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SLTU: single_res = WIDTH'(bus.A < bus.B);
      OP_SLL:  single_res = bus.B << bus.A[4:0];
      OP_SRL:  single_res = bus.B >> bus.A[4:0];
      OP_SRA:  single_res = WIDTH'($signed(bus.B) >>> bus.A[4:0]);
      OP_LUI:  single_res = bus.B << 16;
      OP_MFHI: single_res = hi_q;
      OP_MFLO: single_res = lo_q;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opd_d    = opd_q;
    div_d    = div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_md    = (bus.AluOp[4:2] == 3'b011);
    sgn_op   = ~bus.AluOp[0];
    mag_a    = (sgn_op && bus.A[WIDTH-1]) ? WIDTH'(-bus.A) : bus.A;
    mag_b    = (sgn_op && bus.B[WIDTH-1]) ? WIDTH'(-bus.B) : bus.B;
    sum      = '0;
    rem_sh   = '0;
    prod     = '0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (is_md) begin
            // Multiply: opd = multiplicand, mq = multiplier. Divide: mq = dividend, opd = divisor.
            div_d   = bus.AluOp[1];
            sa_d    = sgn_op & bus.A[WIDTH-1];
            sb_d    = sgn_op & bus.B[WIDTH-1];
            acc_d   = '0;
            mq_d    = bus.AluOp[1] ? mag_a : mag_b;
            opd_d   = bus.AluOp[1] ? mag_b : mag_a;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            result_d = single_res;
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (!div_q) begin
          sum           = mq_q[0] ? (acc_q + {1'b0, opd_q}) : acc_q;
          {acc_d, mq_d} = {1'b0, sum, mq_q[WIDTH-1:1]};
        end else begin
          // Compare instead of borrow so a zero divisor yields all-ones quotient and rem = dividend
          rem_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
          if (rem_sh >= {1'b0, opd_q}) begin
            acc_d = {1'b0, WIDTH'(rem_sh - {1'b0, opd_q})};
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {1'b0, rem_sh[WIDTH-1:0]};
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (!div_q) begin
          prod = {acc_q[WIDTH-1:0], mq_q};
          if (sa_q ^ sb_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = sa_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          if (opd_q == '0)            lo_d = '1;
          else if (sa_q ^ sb_q)       lo_d = WIDTH'(-mq_q);
          else                        lo_d = mq_q;
        end
        result_d = lo_d;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    zero_d = (result_d == '0);
    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opd_q    <= '0;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opd_q    <= opd_d;
      div_q    <= div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = busy_q;
  assign bus.aludone = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: single-cycle op table plus mul/div and handshake corner sequences.
module tb_multicycle_alu;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multicycle_alu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.AluOp = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Single-cycle op: aludone and result one cycle after start, then back to idle
  task automatic single_op(input vec_t v);
    issue(v.op, v.a, v.b);
    chk({v.name, " aludone"}, 64'(bus.aludone), 64'(1));
    chk({v.name, " result"}, 64'(bus.result), 64'(v.res));
    chk({v.name, " zero"}, 64'(bus.zero), 64'(v.res == 32'h0));
    tick();
    chk({v.name, " aludone drop"}, 64'(bus.aludone), 64'(0));
  endtask

  // Mul/div: checks latency 34, busy over cycles 1..33, hi/lo/result; leaves the bench in the DONE cycle
  task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int busy_bad;
    busy_bad = 0;
    issue(op, a, b);
    cyc = 1;
    while (!bus.aludone && cyc < 50) begin
      if (!bus.busy) busy_bad++;
      tick();
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(34));
    chk({name, " busy cycles"}, 64'(busy_bad), 64'(0));
    chk({name, " busy at done"}, 64'(bus.busy), 64'(0));
    chk({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    chk({name, " result"}, 64'(bus.result), 64'(exp_lo));
  endtask

  initial begin
    int dones;
    logic [31:0] seen;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "ADD wrap"};
    vecs[1]  = '{5'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, "SUB"};
    vecs[2]  = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "AND"};
    vecs[3]  = '{5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "OR"};
    vecs[4]  = '{5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "XOR"};
    vecs[5]  = '{5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, "NOR"};
    vecs[6]  = '{5'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "SLT"};
    vecs[7]  = '{5'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "SLTU"};
    vecs[8]  = '{5'd8,  32'h0000_0021, 32'h0000_0003, 32'h0000_0006, "SLL shamt5"};
    vecs[9]  = '{5'd9,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, "SRL"};
    vecs[10] = '{5'd10, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, "SRA"};
    vecs[11] = '{5'd11, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, "LUI"};
    vecs[12] = '{5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, "OP20"};
    vecs[13] = '{5'd0,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, "ADD"};
    vecs[14] = '{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "OP31"};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.AluOp = '0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    chk("reset result", 64'(bus.result), 64'(0));
    chk("reset zero", 64'(bus.zero), 64'(1));
    chk("reset hi", 64'(bus.hi), 64'(0));
    chk("reset lo", 64'(bus.lo), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset aludone", 64'(bus.aludone), 64'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) single_op(vecs[i]);

    run_md("MULT -2*3", 5'd12, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tick();
    chk("MULT aludone pulse", 64'(bus.aludone), 64'(0));
    single_op('{5'd16, 32'h0, 32'h0, 32'hFFFF_FFFF, "MFHI"});
    single_op('{5'd17, 32'h0, 32'h0, 32'hFFFF_FFFA, "MFLO"});

    run_md("MULTU max", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    run_md("DIV -7/2", 5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    run_md("DIV 7/-2", 5'd14, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    tick();
    run_md("DIV minint/-1", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    tick();
    run_md("DIVU 7/0", 5'd15, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    tick();
    run_md("DIV -7/0", 5'd14, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    tick();

    // start pulses during RUN must not queue or restart the multiply
    issue(5'd13, 32'd5, 32'd6);
    dones = 0;
    seen  = '0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.aludone) begin
        dones++;
        seen = bus.result;
      end
      if (c == 5 || c == 20) begin
        bus.AluOp = 5'd0;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    chk("ignore start dones", 64'(dones), 64'(1));
    chk("ignore start result", 64'(seen), 64'(30));
    chk("ignore start lo", 64'(bus.lo), 64'(30));

    // start in the DONE cycle is accepted with normal latency
    run_md("DIVU 100/7", 5'd15, 32'd100, 32'd7, 32'd2, 32'd14);
    issue(5'd0, 32'd2, 32'd3);
    chk("b2b aludone", 64'(bus.aludone), 64'(1));
    chk("b2b result", 64'(bus.result), 64'(5));
    chk("b2b hi kept", 64'(bus.hi), 64'(2));
    tick();
    chk("b2b aludone drop", 64'(bus.aludone), 64'(0));

    // reset in cycle 10 of a MULTU aborts it
    issue(5'd13, 32'd12345, 32'd678);
    for (int c = 1; c < 10; c++) tick();
    chk("pre-reset busy", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort result", 64'(bus.result), 64'(0));
    chk("abort zero", 64'(bus.zero), 64'(1));
    chk("abort hi", 64'(bus.hi), 64'(0));
    chk("abort lo", 64'(bus.lo), 64'(0));
    chk("abort busy", 64'(bus.busy), 64'(0));
    chk("abort aludone", 64'(bus.aludone), 64'(0));
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.aludone) dones++;
      tick();
    end
    chk("abort no aludone", 64'(dones), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
